// File: rtl/mips_pkg.sv
// Purpose: shared MIPS encoding constants and request types, used by the
//          instruction encoder and by the core's main/ALU decoders.
package mips_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned TGT_W  = 26;
  localparam int unsigned KIND_W = 4;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [KIND_W-1:0] {
    KIND_ADD  = 4'd0,
    KIND_SUB  = 4'd1,
    KIND_AND  = 4'd2,
    KIND_OR   = 4'd3,
    KIND_SLT  = 4'd4,
    KIND_LW   = 4'd5,
    KIND_SW   = 4'd6,
    KIND_BEQ  = 4'd7,
    KIND_ADDI = 4'd8,
    KIND_J    = 4'd9
  } req_kind_e;

  // Symbolic instruction request payload
  typedef struct packed {
    logic [KIND_W-1:0] kind;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [IMM_W-1:0]  imm;
    logic [TGT_W-1:0]  target;
  } req_s;

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Purpose: request and instruction-memory write bundle of the encoder.
//   master: request producer / memory consumer (harness, boot loader)
//   slave : the encoder
interface mips_instr_encoder_if;
  import mips_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [KIND_W-1:0] req_kind;
  logic [REG_W-1:0]  req_rs;
  logic [REG_W-1:0]  req_rt;
  logic [REG_W-1:0]  req_rd;
  logic [IMM_W-1:0]  req_imm;
  logic [TGT_W-1:0]  req_target;
  logic              imem_we;
  logic [WORD_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;

  modport master (
    output req_valid, req_kind, req_rs, req_rt, req_rd, req_imm, req_target,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  req_valid, req_kind, req_rs, req_rt, req_rd, req_imm, req_target,
    output req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/mips_instr_pack.sv
// Purpose: combinational packer, symbolic request -> 32-bit MIPS word.
//   req_i   : request payload (kind + fields)
//   word_o  : encoded word (NOP_WORD for an illegal kind)
//   legal_o : kind is one of the ten supported instructions
module mips_instr_pack
  import mips_pkg::*;
(
  input  req_s              req_i,
  output logic [WORD_W-1:0] word_o,
  output logic              legal_o
);

  // R-type word with shamt fixed at zero
  function automatic logic [WORD_W-1:0] r_word(input req_s r, input logic [5:0] fn);
    return {OP_RTYPE, r.rs, r.rt, r.rd, 5'd0, fn};
  endfunction

  // I-type word; rd is not part of the format
  function automatic logic [WORD_W-1:0] i_word(input req_s r, input logic [5:0] op);
    return {op, r.rs, r.rt, r.imm};
  endfunction

  always_comb begin
    word_o  = NOP_WORD;
    legal_o = 1'b1;
    case (req_kind_e'(req_i.kind))
      KIND_ADD:  word_o = r_word(req_i, FN_ADD);
      KIND_SUB:  word_o = r_word(req_i, FN_SUB);
      KIND_AND:  word_o = r_word(req_i, FN_AND);
      KIND_OR:   word_o = r_word(req_i, FN_OR);
      KIND_SLT:  word_o = r_word(req_i, FN_SLT);
      KIND_LW:   word_o = i_word(req_i, OP_LW);
      KIND_SW:   word_o = i_word(req_i, OP_SW);
      KIND_BEQ:  word_o = i_word(req_i, OP_BEQ);
      KIND_ADDI: word_o = i_word(req_i, OP_ADDI);
      KIND_J:    word_o = {OP_J, req_i.target};
      default:   legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Purpose: accepts symbolic instruction requests, encodes them and writes the
//          words in order into instruction memory starting at BASE_ADDR.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : synchronous restart (address, count, err)
//   bus        : request handshake + registered imem write port (slave side)
//   count/full : words written since reset/clear, count == DEPTH
//   err        : sticky illegal-kind flag
// Option: MIPS_ENC_ILLEGAL_CHECK_EN -- drop illegal kinds and flag err;
//         otherwise illegal kinds are written as NOP and err stays 0.
module mips_instr_encoder
  import mips_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  mips_instr_encoder_if.slave        bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       err
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] waddr_q, waddr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;

  req_s              req_c;
  logic [WORD_W-1:0] pack_word_c;
  logic              pack_legal_c;
  logic [WORD_W-1:0] word_c;
  logic              full_c;
  logic              ready_c;
  logic              accept_c;
  logic              write_c;
  logic              err_set_c;

  assign req_c = '{kind:   bus.req_kind,
                   rs:     bus.req_rs,
                   rt:     bus.req_rt,
                   rd:     bus.req_rd,
                   imm:    bus.req_imm,
                   target: bus.req_target};

  mips_instr_pack u_pack (
    .req_i   (req_c),
    .word_o  (pack_word_c),
    .legal_o (pack_legal_c)
  );

  assign full_c   = (count_q == CNT_W'(DEPTH));
  assign ready_c  = !full_c && !clear;
  assign accept_c = bus.req_valid && ready_c;

  // Illegal-kind policy
`ifdef MIPS_ENC_ILLEGAL_CHECK_EN
  assign word_c    = pack_word_c;
  assign write_c   = accept_c && pack_legal_c;
  assign err_set_c = accept_c && !pack_legal_c;
`else
  assign word_c    = pack_legal_c ? pack_word_c : NOP_WORD;
  assign write_c   = accept_c;
  assign err_set_c = 1'b0;
`endif

  // Next-state: clear wins over any same-cycle request
  always_comb begin
    addr_d  = addr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    count_d = count_q;
    err_d   = err_q;
    if (clear) begin
      addr_d  = BASE_ADDR;
      waddr_d = BASE_ADDR;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (write_c) begin
        we_d    = 1'b1;
        waddr_d = addr_q;
        wdata_d = word_c;
        addr_d  = addr_q + 32'd4;
        count_d = count_q + CNT_W'(1);
      end
      if (err_set_c) err_d = 1'b1;
    end
  end

  // State and registered write port; reset discards a pending write at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= BASE_ADDR;
      waddr_q <= BASE_ADDR;
      wdata_q <= '0;
      we_q    <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign count          = count_q;
  assign full           = full_c;
  assign err            = err_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Purpose: self-checking bench for mips_instr_encoder (DEPTH=4) with a write
//          scoreboard; adapts to MIPS_ENC_ILLEGAL_CHECK_EN.
module tb_mips_instr_encoder;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef MIPS_ENC_ILLEGAL_CHECK_EN
  localparam bit ILL_CHK = 1'b1;
`else
  localparam bit ILL_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic [2:0] count;
  logic       full;
  logic       err;

  mips_instr_encoder_if bus ();

  mips_instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus),
    .count (count),
    .full  (full),
    .err   (err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] sb[$];
  logic [31:0] exp_addr = BASE;
  int          exp_count = 0;
  logic        exp_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoder written straight from the instruction formats
  function automatic logic [31:0] enc(input int k, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [15:0] imm,
                                      input logic [25:0] tg);
    case (k)
      0: return {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      1: return {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
      2: return {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
      3: return {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
      4: return {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
      5: return {6'b100011, rs, rt, imm};
      6: return {6'b101011, rs, rt, imm};
      7: return {6'b000100, rs, rt, imm};
      8: return {6'b001000, rs, rt, imm};
      9: return {6'b000010, tg};
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Scoreboard consumer: every observed write must match the oldest expectation
  always @(negedge clk) begin
    if (!reset && bus.imem_we) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {32'h0, bus.imem_addr}, 64'h0);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        check("imem_addr", 64'(bus.imem_addr), 64'(e[63:32]));
        check("imem_wdata", 64'(bus.imem_wdata), 64'(e[31:0]));
      end
    end
  end

  // One request cycle; exp_word is the word required if it gets written
  task automatic send(input int k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm,
                      input logic [25:0] tg, input logic [31:0] exp_word);
    bit legal;
    bus.req_kind = 4'(k); bus.req_rs = rs; bus.req_rt = rt; bus.req_rd = rd;
    bus.req_imm = imm; bus.req_target = tg; bus.req_valid = 1'b1;
    @(negedge clk);
    check("req_ready", 64'(bus.req_ready), 64'(exp_count < DEPTH && !clear));
    if (exp_count < DEPTH && !clear) begin
      legal = (k <= 9);
      if (legal || !ILL_CHK) begin
        sb.push_back({exp_addr, exp_word});
        exp_addr  = exp_addr + 32'd4;
        exp_count = exp_count + 1;
      end else begin
        exp_err = 1'b1;
      end
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    check({tag, "_count"}, 64'(count), 64'(exp_count));
    check({tag, "_full"}, 64'(full), 64'(exp_count == DEPTH));
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_addr = BASE; exp_count = 0; exp_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_kind = '0; bus.req_rs = '0; bus.req_rt = '0;
    bus.req_rd = '0; bus.req_imm = '0; bus.req_target = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we", 64'(bus.imem_we), 64'd0);
    check("rst_addr", 64'(bus.imem_addr), 64'(BASE));
    check("rst_wdata", 64'(bus.imem_wdata), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_ready", 64'(bus.req_ready), 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // ADD then back-to-back LW/SW/ADDI; fourth word fills DEPTH=4
    send(0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0022_1820);
    send(5, 5'd1, 5'd2, 5'd0, 16'd4, 26'h0, 32'h8C22_0004);
    send(6, 5'd0, 5'd2, 5'd0, 16'd8, 26'h0, 32'hAC02_0008);
    send(8, 5'd0, 5'd1, 5'd0, 16'd5, 26'h0, 32'h2001_0005);
    check_state("after4");
    check("full_ready", 64'(bus.req_ready), 64'd0);
    do_clear();

    // BEQ negative offset, then J
    send(7, 5'd1, 5'd2, 5'd7, 16'hFFFF, 26'h0, 32'h1022_FFFF);
    send(9, 5'd3, 5'd4, 5'd5, 16'h1234, 26'h10, 32'h0800_0010);
    check_state("beq_j");
    do_clear();

    // Hold valid for 6 random legal requests: only 4 may be written
    for (int i = 0; i < 6; i++) begin
      int k;
      logic [4:0] rs, rt, rd;
      logic [15:0] imm;
      logic [25:0] tg;
      k = int'($urandom_range(0, 9));
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      imm = 16'($urandom); tg = 26'($urandom);
      send(k, rs, rt, rd, imm, tg, enc(k, rs, rt, rd, imm, tg));
    end
    check_state("hold6");
    do_clear();
    check_state("cleared");

    // clear beats a same-cycle request: no write may appear
    clear = 1'b1;
    send(1, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 32'h0);
    clear = 1'b0;
    check_state("clr_prio");

    // Illegal kind, then a legal word
    send(12, 5'd9, 5'd9, 5'd9, 16'h9, 26'h9, 32'h0000_0000);
    check_state("illegal");
    send(3, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, enc(3, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0));
    check_state("post_ill");
    do_clear();

    // Reset while a write is pending
    send(2, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, enc(2, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0));
    check("pend_we", 64'(bus.imem_we), 64'd1);
    reset = 1'b1;
    #1;
    check("arst_we", 64'(bus.imem_we), 64'd0);
    check("arst_addr", 64'(bus.imem_addr), 64'(BASE));
    check("arst_wdata", 64'(bus.imem_wdata), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_err", 64'(err), 64'd0);
    check("arst_ready", 64'(bus.req_ready), 64'd1);
    sb.delete();
    exp_addr = BASE; exp_count = 0; exp_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    send(4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, enc(4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0));
    check_state("post_rst");

    idle(2);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Sequential instruction encoder that packs symbolic instruction requests (kind, register fields, immediate/target) into 32-bit MIPS words, then writes them in order into the instruction memory of the single-cycle core. It is the producer side of the opcode/funct encoding that the core's main and ALU decoders consume, and is used by self-loading test harnesses and the boot loader. It has a valid/ready request interface, a registered memory write port, an address counter, a capacity limit and a sticky error flag.

## Interface
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- DEPTH, 64, maximum number of words written before full (power of two not required, ≥1).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous reset, active-high.
- clear  in  1  synchronous restart: address to BASE_ADDR, count to 0, err to 0.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_kind  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 ADDI, 9 J, 10–15 illegal.
- req_rs, req_rt, req_rd  in  5 each  register fields.
- req_imm  in  16  immediate / branch offset (words, two's complement).
- req_target  in  26  jump target field.
- imem_we  out  1  write strobe, one cycle per word.
- imem_addr  out  32  byte address of the write.
- imem_wdata  out  32  encoded word.
- count  out  $clog2(DEPTH+1)  words written since reset/clear.
- full  out  1  count == DEPTH.
- err  out  1  sticky: an illegal kind was accepted.

## Operation
- Accept on req_valid && req_ready; req_ready = !full && !clear.
- R-type (kinds 0–4): op 6'b000000, rs[25:21], rt[20:16], rd[15:11], shamt 0, funct 0x20/0x22/0x24/0x25/0x2A.
- LW op 0x23, SW op 0x2B, BEQ op 0x04, ADDI op 0x08: rs[25:21], rt[20:16], imm[15:0]; req_rd ignored.
- J op 0x02, target[25:0]; other fields ignored.
- Legal word: registered into imem_wdata, imem_we=1, imem_addr=current address; address += 4, count += 1 in the same edge.
- Address arithmetic 32-bit, wraps modulo 2^32 without flagging.
- clear has priority over a same-cycle request (request not accepted, no write).
- Memory always accepts; no downstream backpressure.

## Timing
- Reset values: req_ready 1 (0 if DEPTH==0 is illegal, not supported), imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, count 0, full 0, err 0.
- Latency: accept at edge N → imem_we high during cycle N+1 only; back-to-back accepts give a write every cycle.
- full asserts the cycle after the DEPTH-th accept; req_ready drops with it; no write is ever issued past DEPTH.
- Reset mid-stream: pending write discarded immediately (imem_we forced 0 asynchronously).
- clear cycle: imem_we 0 the following cycle; a write already registered before clear still completes.

## Configuration
- MIPS_ENC_ILLEGAL_CHECK_EN defined: illegal kind accepted, no write, address/count unchanged, err set next cycle.
- Undefined: illegal kind encoded as 32'h0000_0000 (NOP), written and counted like a legal word; err ties to 0.

## Structure
- Shared package mips_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), funct constants, req_kind enum typedef; the core's decoders use the same constants.
- One sub-module mips_instr_pack: combinational kind/fields → {word, legal}; the top holds handshake, counter, address and flags.

## Test plan
- ADD rs=1 rt=2 rd=3 after reset → cycle+1: imem_we=1, addr 0x0, wdata 0x00221820; count 1.
- Back-to-back LW rs=1 rt=2 imm=4, SW rs=0 rt=2 imm=8, ADDI rs=0 rt=1 imm=5 → words 0x8C220004, 0xAC020008, 0x20010005 at 0x0, 0x4, 0x8 on consecutive cycles.
- BEQ rs=1 rt=2 imm=-1 then J target=0x10 → 0x1022FFFF, 0x08000010.
- DEPTH=4, hold req_valid for 6 requests → exactly 4 writes, full=1 and req_ready=0 afterwards; clear → addr back to BASE_ADDR, count 0, ready 1.
- kind 12 with macro → no write, err=1, next legal word lands at unchanged address; without macro → 0x00000000 written, err=0.
- reset asserted in the cycle after an accept → imem_we 0 immediately, all outputs at reset values.
